led_cmd_ctrl: RTL and testbench

Command sequencer for the board LEDs. Consumes decoded SPI command bytes (`cmd`/`cmd_valid`, already in the `clk` domain from the SPI slave) and drives four LEDs in static, blink or chase mode. Blink and chase are paced by an internal programmable tick. It sits between the SPI slave and the LED pins in the top level.

---
 rtl/led_cmd_pkg.sv | 34 +++
 rtl/led_cmd_ctrl_tick_gen.sv | 39 +++
 rtl/led_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_led_cmd_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_cmd_pkg
// Description : Shared opcodes, mode/state encodings and helpers for the LED
//               command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package led_cmd_pkg;

    localparam logic [3:0] OP_SET    = 4'h0;
    localparam logic [3:0] OP_BLINK  = 4'h1;
    localparam logic [3:0] OP_CHASE  = 4'h2;
    localparam logic [7:0] OP_PERIOD = 8'hA0;
    localparam logic [7:0] OP_CLRERR = 8'hF0;

    localparam logic [7:0] RESET_PERIOD = 8'd15;

    typedef enum logic {
        STATIC = 1'b0,
        CHASE  = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_e;

    // One step of the chase pattern: rotate left by one LED.
    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_cmd_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Prescaler plus period divider; one-cycle tick every
//               (period+1)*2^PRESC_W clocks, restartable.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int PRESC_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic [7:0] period,
    output logic       tick
);

    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_div;
    logic               w_presc_wrap;

    assign w_presc_wrap = &r_presc;
    // Divider never exceeds period because period only changes together with restart.
    assign tick         = w_presc_wrap && (r_div == period);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_presc <= '0;
            r_div   <= 8'd0;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_presc_wrap) begin
                r_div <= tick ? 8'd0 : r_div + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_cmd_ctrl
// Description : SPI-fed LED command sequencer: static/blink/chase modes with a
//               programmable tick, argument timeout and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module led_cmd_ctrl
    import led_cmd_pkg::*;
#(
    parameter int PRESC_W        = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_valid,
    output logic [3:0] led,
    output logic       busy,
    output logic       err
);

    localparam int              c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [0:0] c_IDLE = IDLE;
    localparam logic [0:0] c_ARG  = ARG;

    logic [0:0]        r_state;
    mode_e             r_mode;
    logic [3:0]        r_led_reg;
    logic [3:0]        r_mask;
    logic [3:0]        r_chase;
    logic [7:0]        r_period;
    logic              r_phase;
    logic              r_err;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [3:0]        r_led;
    logic              r_busy;

    logic [0:0]        w_state_nxt;
    mode_e             w_mode_nxt;
    logic [3:0]        w_led_reg_nxt;
    logic [3:0]        w_mask_nxt;
    logic [3:0]        w_chase_nxt;
    logic [7:0]        w_period_nxt;
    logic              w_phase_nxt;
    logic              w_err_nxt;
    logic [c_TO_W-1:0] w_to_nxt;
    logic [3:0]        w_led_nxt;
    logic              w_restart;
    logic              w_load;
    logic              w_tick;

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .period  (r_period),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_led_reg_nxt = r_led_reg;
        w_mask_nxt    = r_mask;
        w_chase_nxt   = r_chase;
        w_period_nxt  = r_period;
        w_err_nxt     = r_err;
        w_to_nxt      = r_to_cnt;
        w_restart     = 1'b0;
        w_load        = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (cmd_valid) begin
                    if (cmd == OP_PERIOD) begin
                        w_state_nxt = c_ARG;
                        w_to_nxt    = '0;
                    end else if (cmd == OP_CLRERR) begin
                        w_err_nxt = 1'b0;
                    end else begin
                        case (cmd[7:4])
                            OP_SET: begin
                                w_mode_nxt    = STATIC;
                                w_led_reg_nxt = cmd[3:0];
                                w_mask_nxt    = 4'h0;
                                w_load        = 1'b1;
                            end
                            OP_BLINK: begin
                                w_mode_nxt = STATIC;
                                w_mask_nxt = cmd[3:0];
                                w_load     = 1'b1;
                            end
                            OP_CHASE: begin
                                w_mode_nxt  = CHASE;
                                w_chase_nxt = 4'b0001;
                                w_load      = 1'b1;
                            end
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                end
            end
            c_ARG: begin
                // Any strobed byte is the argument, even one that looks like an opcode.
                if (cmd_valid) begin
                    w_period_nxt = cmd;
                    w_restart    = 1'b1;
                    w_state_nxt  = c_IDLE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase

        w_phase_nxt = r_phase ^ w_tick;
        // A freshly loaded pattern wins over the rotate of a coincident tick.
        if (w_tick && (r_mode == CHASE) && !w_load) begin
            w_chase_nxt = rotl4(r_chase);
        end

        if (w_mode_nxt == CHASE) begin
            w_led_nxt = w_chase_nxt;
        end else begin
            w_led_nxt = w_led_reg_nxt ^ (w_mask_nxt & {4{w_phase_nxt}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mode    <= STATIC;
            r_led_reg <= 4'h0;
            r_mask    <= 4'h0;
            r_chase   <= 4'b0001;
            r_period  <= RESET_PERIOD;
            r_phase   <= 1'b0;
            r_err     <= 1'b0;
            r_to_cnt  <= '0;
            r_led     <= 4'h0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_led_reg <= w_led_reg_nxt;
            r_mask    <= w_mask_nxt;
            r_chase   <= w_chase_nxt;
            r_period  <= w_period_nxt;
            r_phase   <= w_phase_nxt;
            r_err     <= w_err_nxt;
            r_to_cnt  <= w_to_nxt;
            r_led     <= w_led_nxt;
            r_busy    <= (w_state_nxt == c_ARG);
        end
    end

    assign led  = r_led;
    assign busy = r_busy;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_led_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_cmd_ctrl
// Description : Directed plus randomized bench for led_cmd_ctrl, checked each
//               cycle against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_cmd_ctrl;

    localparam int PW = 2;
    localparam int TO = 64;

    logic       clk;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [3:0] led;
    logic       busy;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    led_cmd_ctrl #(
        .PRESC_W        (PW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .led       (led),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ticks derived from edges elapsed since the last restart.
    int unsigned m_edge      = 0;
    int unsigned m_restart   = 0;
    int unsigned m_arg_entry = 0;
    bit          m_chase_mode;
    bit [3:0]    m_ledreg;
    bit [3:0]    m_mask;
    bit [7:0]    m_period;
    bit          m_phase;
    int          m_chase_idx;
    bit          m_arg;
    bit          m_err;

    function automatic logic [3:0] exp_led();
        logic [3:0] one_hot;
        one_hot = 4'(1 << m_chase_idx);
        if (m_chase_mode) return one_hot;
        return m_ledreg ^ (m_phase ? m_mask : 4'h0);
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [7:0] c);
        int len;
        bit tick;
        bit was_chase;
        bit loaded;
        m_edge++;
        if (r) begin
            m_chase_mode = 0; m_ledreg = 0; m_mask = 0; m_period = 8'd15;
            m_phase = 0; m_chase_idx = 0; m_arg = 0; m_err = 0;
            m_restart = m_edge;
            return;
        end
        len       = (int'(m_period) + 1) * (1 << PW);
        tick      = ((m_edge - m_restart) % len) == 0;
        was_chase = m_chase_mode;
        loaded    = 0;
        if (m_arg) begin
            if (v) begin
                m_period  = c;
                m_restart = m_edge;
                m_arg     = 0;
            end else if (m_edge - m_arg_entry == TO) begin
                m_err = 1;
                m_arg = 0;
            end
        end else if (v) begin
            if (c == 8'hA0) begin
                m_arg = 1;
                m_arg_entry = m_edge;
            end else if (c == 8'hF0) begin
                m_err = 0;
            end else if (c[7:4] == 4'h0) begin
                m_chase_mode = 0; m_ledreg = c[3:0]; m_mask = 0; loaded = 1;
            end else if (c[7:4] == 4'h1) begin
                m_chase_mode = 0; m_mask = c[3:0]; loaded = 1;
            end else if (c[7:4] == 4'h2) begin
                m_chase_mode = 1; m_chase_idx = 0; loaded = 1;
            end else begin
                m_err = 1;
            end
        end
        if (tick) begin
            m_phase = !m_phase;
            if (was_chase && !loaded) m_chase_idx = (m_chase_idx + 1) % 4;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] c);
        logic [3:0] e_led;
        rst = r; cmd_valid = v; cmd = c;
        @(posedge clk);
        #1;
        model_edge(r, v, c);
        e_led = exp_led();
        n_vec++;
        assert (led === e_led) else begin
            n_err++;
            $error("FAIL led vec=%0d observed=%b expected=%b", n_vec, led, e_led);
        end
        assert (busy === m_arg) else begin
            n_err++;
            $error("FAIL busy vec=%0d observed=%b expected=%b", n_vec, busy, m_arg);
        end
        assert (err === m_err) else begin
            n_err++;
            $error("FAIL err vec=%0d observed=%b expected=%b", n_vec, err, m_err);
        end
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b0, 1'b1, c);
    endtask

    // Idle cycles carry random junk on cmd to show it is ignored without a strobe.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic check_lit(input string tag, input logic [3:0] got, input logic [3:0] want);
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    initial begin
        logic [3:0] held;
        logic [7:0] c;
        int         dens;
        int         sel;

        rst = 1'b1; cmd_valid = 1'b0; cmd = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check_lit("reset_led", led, 4'h0);
        check_lit("reset_busy", {3'b0, busy}, 4'h0);
        check_lit("reset_err", {3'b0, err}, 4'h0);

        // Static SET holds through several ticks.
        send(8'h05);
        check_lit("set_05", led, 4'b0101);
        idle(200);
        check_lit("set_05_hold", led, 4'b0101);

        // Argument timeout with the reset period.
        send(8'hA0);
        check_lit("busy_rise", {3'b0, busy}, 4'h1);
        idle(TO - 1);
        check_lit("busy_last", {3'b0, busy}, 4'h1);
        idle(1);
        check_lit("busy_fall", {3'b0, busy}, 4'h0);
        check_lit("timeout_err", {3'b0, err}, 4'h1);
        send(8'h1F);
        idle(140);

        // Invalid opcode, clear, and opcode-looking argument.
        send(8'hF0);
        check_lit("clrerr", {3'b0, err}, 4'h0);
        held = led;
        send(8'h55);
        check_lit("invalid_err", {3'b0, err}, 4'h1);
        check_lit("invalid_led", led, held);
        send(8'hF0);
        send(8'hA0);
        send(8'hF0);
        check_lit("arg_f0_err", {3'b0, err}, 4'h0);
        idle(2000);

        // Reset during ARG discards the pending argument.
        send(8'hA0);
        step(1'b1, 1'b0, 8'h00);
        check_lit("rst_busy", {3'b0, busy}, 4'h0);
        send(8'h09);
        check_lit("rst_set_09", led, 4'b1001);
        send(8'h1F);
        idle(140);

        // Fastest chase.
        send(8'hA0);
        send(8'h00);
        send(8'h2F);
        check_lit("chase_start", led, 4'b0001);
        idle(40);

        // Blink with period 1.
        send(8'h03);
        send(8'h11);
        send(8'hA0);
        send(8'h01);
        idle(60);

        // Randomized traffic in segments of varying strobe density.
        for (int seg = 0; seg < 40; seg++) begin
            sel  = $urandom_range(0, 2);
            dens = (sel == 0) ? 2 : (sel == 1) ? 20 : 100;
            for (int i = 0; i < 100; i++) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2: c = {4'h0, 4'($urandom)};
                    3, 4:    c = {4'h1, 4'($urandom)};
                    5:       c = {4'h2, 4'($urandom)};
                    6:       c = 8'hA0;
                    7:       c = 8'hF0;
                    default: c = 8'($urandom);
                endcase
                if ($urandom_range(0, 599) == 0) step(1'b1, 1'b0, c);
                else step(1'b0, ($urandom % dens) == 0, c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
